// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width and word type for the registered ripple adder
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] adder_word_t;

endpackage : adder_pkg

// File: rtl/full_adder_str.sv
// rtl/full_adder_str.sv - 1-bit structural full adder built from gate primitives
module full_adder_str (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g;
    logic pc;

    // propagate and generate terms of this bit
    xor u_xor_p (p, a, b);
    and u_and_g (g, a, b);

    // sum bit and carry to the next stage
    xor u_xor_s  (s, p, cin);
    and u_and_pc (pc, p, cin);
    or  u_or_c   (cout, g, pc);

endmodule : full_adder_str

// File: rtl/four_bit_ripple_adder.sv
// rtl/four_bit_ripple_adder.sv - registered ripple-carry adder; optional signed overflow output under RIPPLE_ADDER_OVF_EN
module four_bit_ripple_adder
    import adder_pkg::*;
#(
    // must equal ADDER_WIDTH because the operand ports use adder_word_t
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  adder_word_t a,
    input  adder_word_t b,
    input  logic        cin,
    output adder_word_t sum,
    output logic        cout,
`ifdef RIPPLE_ADDER_OVF_EN
    output logic        ovf,
`endif
    output logic        out_valid
);

    // carry chain: c[0] is the external carry in, c[WIDTH] the carry out
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // one full adder per bit, carry rippling LSB to MSB
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_str u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // result registers load only on valid operands; valid tracks every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef RIPPLE_ADDER_OVF_EN
    // signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule : four_bit_ripple_adder

// File: tb/tb_four_bit_ripple_adder.sv
// tb/tb_four_bit_ripple_adder.sv - randomized and directed self-checking bench for four_bit_ripple_adder
module tb_four_bit_ripple_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_sum   = 0;
    int m_cout  = 0;
    int m_valid = 0;
    int m_ovf   = 0;

    four_bit_ripple_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
`ifdef RIPPLE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".sum"},       int'(sum),       m_sum);
        check_eq({tag, ".cout"},      int'(cout),      m_cout);
        check_eq({tag, ".out_valid"}, int'(out_valid), m_valid);
`ifdef RIPPLE_ADDER_OVF_EN
        check_eq({tag, ".ovf"},       int'(ovf),       m_ovf);
`endif
    endtask

    // model: plain integer arithmetic, unsigned and signed views
    task automatic model_update(input int ta, input int tb_, input int tc, input int tv);
        int u;
        int sv;
        int sa;
        int sb;
        m_valid = tv;
        if (tv != 0) begin
            u  = ta + tb_ + tc;
            sa = (ta >= 8) ? ta - 16 : ta;
            sb = (tb_ >= 8) ? tb_ - 16 : tb_;
            sv = sa + sb + tc;
            m_sum  = u % 16;
            m_cout = u / 16;
            m_ovf  = (sv > 7 || sv < -8) ? 1 : 0;
        end
    endtask

    task automatic apply(input int ta, input int tb_, input int tc, input int tv, input string tag);
        @(negedge clk);
        a        = 4'(ta);
        b        = 4'(tb_);
        cin      = 1'(tc);
        in_valid = 1'(tv);
        @(posedge clk);
        #1;
        model_update(ta, tb_, tc, tv);
        check_outputs(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // outputs held at zero while reset is low, across clock edges
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // first capture after reset release
        apply(4, 5, 0, 1, "first_capture");

        // asynchronous reset mid-cycle with a pending operand set
        a        = 4'd1;
        b        = 4'd1;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        m_sum = 0; m_cout = 0; m_valid = 0; m_ovf = 0;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_low_edge");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // sweep of the low operand range
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                apply(i, j, 0, 1, $sformatf("sweep_%0d_%0d", i, j));
            end
        end

        // carry-in and full ripple boundaries
        apply(7, 7, 1, 1, "cin_7_7");
        apply(0, 0, 1, 1, "cin_0_0");
        apply(15, 1, 0, 1, "ripple_15_1");
        apply(15, 15, 1, 1, "ripple_15_15_1");
        apply(0, 0, 0, 1, "zero");
        check_eq("zero_literal_sum", int'(sum), 0);
        apply(15, 15, 1, 1, "allones");
        check_eq("allones_literal_sum", int'(sum), 15);
        check_eq("allones_literal_cout", int'(cout), 1);

        // hold while in_valid is low
        apply(3, 4, 0, 1, "hold_load");
        for (int k = 0; k < 3; k++) begin
            apply(9, 9, 0, 0, $sformatf("hold_%0d", k));
        end
        check_eq("hold_literal_sum", int'(sum), 7);

`ifdef RIPPLE_ADDER_OVF_EN
        apply(7, 1, 0, 1, "ovf_7_1");
        check_eq("ovf_7_1_literal", int'(ovf), 1);
        apply(8, 8, 0, 1, "ovf_8_8");
        check_eq("ovf_8_8_literal", int'(ovf), 1);
        apply(3, 2, 0, 1, "ovf_3_2");
        check_eq("ovf_3_2_literal", int'(ovf), 0);
`endif

        // randomized operands with random valid gaps
        for (int n = 0; n < 300; n++) begin
            apply(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)), ($urandom_range(3) != 0) ? 1 : 0,
                  $sformatf("rand_%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_four_bit_ripple_adder
